// File: rtl/fetch_unit_pkg.sv
// Shared MIPS definitions: opcodes, NOP encoding, reset vector and next-PC source encoding.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_HOLD   = 2'd1,
        PC_SRC_BRANCH = 2'd2,
        PC_SRC_JUMP   = 2'd3
    } pc_src_e;

    // Instruction addresses are word aligned; low two bits are always discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: branch beats jump beats stall beats sequential PC+4.
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [3:0]  pc_region_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o
);

    pc_src_e     pc_src_s;
    logic [31:0] jump_target_s;

    assign jump_target_s = {pc_region_i, jump_index_i, 2'b00};

    // Priority resolution of the PC source.
    always_comb begin
        pc_src_s   = PC_SRC_SEQ;
        redirect_o = 1'b0;
        if (branch_taken_i) begin
            pc_src_s   = PC_SRC_BRANCH;
            redirect_o = 1'b1;
        end else if (jump_i) begin
            pc_src_s   = PC_SRC_JUMP;
            redirect_o = 1'b1;
        end else if (stall_i) begin
            pc_src_s   = PC_SRC_HOLD;
        end else begin
            pc_src_s   = PC_SRC_SEQ;
        end
    end

    // Next-PC mux; sequential increment wraps modulo 2^32.
    always_comb begin
        next_pc_o = pc_i + 32'd4;
        case (pc_src_s)
            PC_SRC_BRANCH: next_pc_o = word_align(branch_target_i);
            PC_SRC_JUMP:   next_pc_o = word_align(jump_target_s);
            PC_SRC_HOLD:   next_pc_o = pc_i;
            PC_SRC_SEQ:    next_pc_o = pc_i + 32'd4;
            default:       next_pc_o = pc_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,          pc_d;
    logic [31:0] if_instr_q,    if_instr_d;
    logic [31:0] if_pc_q,       if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic        if_valid_q,    if_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        redirect_s;

    // Jump region comes from the instruction in IF/ID, not from the fetch PC.
    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .pc_region_i     (if_pc_plus4_q[31:28]),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .next_pc_o       (pc_d),
        .redirect_o      (redirect_s)
    );

    // IF/ID next state: bubble on squash or redirect, hold on stall, otherwise load.
    always_comb begin
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
        if (flush || redirect_s) begin
            if_instr_d    = NOP_WORD;
            if_pc_d       = 32'h0000_0000;
            if_pc_plus4_d = 32'h0000_0000;
            if_valid_d    = 1'b0;
        end else if (stall) begin
            if_valid_d    = if_valid_q;
        end else begin
            if_instr_d    = imem_data;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_q + 32'd4;
            if_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= word_align(RESET_PC);
            if_instr_q    <= NOP_WORD;
            if_pc_q       <= 32'h0000_0000;
            if_pc_plus4_q <= 32'h0000_0000;
            if_valid_q    <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_valid    = if_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a reference model feeding an expectation queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] if_instr, if_pc, if_pc_plus4, fetch_count;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    bit   m_init = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_data = imem_word(imem_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_valid      (if_valid),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, push, clock, pop and compare.
    task automatic step(input logic r, input logic st, input logic fl, input logic br,
                        input logic [31:0] bt, input logic jp, input logic [25:0] ji);
        exp_t        e;
        exp_t        got;
        logic [31:0] jt;
        rst = r; stall = st; flush = fl; branch_taken = br;
        branch_target = bt; jump = jp; jump_index = ji;
        #1;
        if (m_init) check("imem_addr_pre", imem_addr, m.pc);
        if (r) begin
            e = '{32'h0000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        end else begin
            e = m;
            jt = {m.ipc4[31:28], ji, 2'b00};
            if (br)      e.pc = {bt[31:2], 2'b00};
            else if (jp) e.pc = jt;
            else if (st) e.pc = m.pc;
            else         e.pc = m.pc + 32'd4;
            if (fl || br || jp) begin
                e.instr = 32'h0; e.ipc = 32'h0; e.ipc4 = 32'h0; e.valid = 1'b0;
            end else if (!st) begin
                e.instr = imem_word(m.pc); e.ipc = m.pc; e.ipc4 = m.pc + 32'd4;
                e.valid = 1'b1; e.cnt = m.cnt + 32'd1;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("imem_addr",   imem_addr,         got.pc);
        check("if_instr",    if_instr,          got.instr);
        check("if_pc",       if_pc,             got.ipc);
        check("if_pc_plus4", if_pc_plus4,       got.ipc4);
        check("if_valid",    {31'h0, if_valid}, {31'h0, got.valid});
        check("fetch_count", fetch_count,       got.cnt);
        m = got;
        m_init = 1'b1;
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;
        @(posedge clk); #1;

        // reset and first cycles
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        check("reset_imem_addr", imem_addr, 32'h0000_0000);
        check("reset_count", fetch_count, 32'h0);
        free(2);
        check("free_imem_addr_8", imem_addr, 32'h8);
        check("free_if_pc_4", if_pc, 32'h4);

        // stall two cycles at PC=8
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        check("stall_imem_addr", imem_addr, 32'h8);
        check("stall_if_pc", if_pc, 32'h4);
        check("stall_count", fetch_count, 32'h2);
        free(1);
        check("free_count_3", fetch_count, 32'h3);
        check("free_if_pc_8", if_pc, 32'h8);
        free(5);
        check("at_pc_32", imem_addr, 32'h20);

        // branch to 0x10
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 26'h0);
        check("br_imem_addr", imem_addr, 32'h10);
        check("br_bubble", {31'h0, if_valid}, 32'h0);
        free(1);
        check("br_if_pc", if_pc, 32'h10);

        // branch and jump together, unaligned target
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h21, 1'b1, 26'h0);
        check("br_wins", imem_addr, 32'h20);
        free(1);

        // jump with stall: redirect overrides stall
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h40);
        check("jump_stall", imem_addr, 32'h100);
        free(2);

        // flush alone, then flush with stall
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        free(1);

        // jump region taken from if_pc_plus4
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 1'b0, 26'h0);
        free(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF);
        check("jump_region", imem_addr, 32'hFFFF_FFFC);

        // wrap at top of address space, unaligned branch target
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'h0);
        free(1);
        check("wrap_imem_addr", imem_addr, 32'h0);
        check("wrap_if_pc_plus4", if_pc_plus4, 32'h0);
        free(3);

        // reset mid stall and jump
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h155);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        free(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: stall  input  1  hold PC and IF/ID register.
REQ-005 Port: flush  input  1  squash IF/ID contents (insert bubble).
REQ-006 Port: branch_taken  input  1  redirect PC to branch_target.
REQ-007 Port: branch_target  input  32  full byte address of branch destination.
REQ-008 Port: jump  input  1  redirect PC to J-type target.
REQ-009 Port: jump_index  input  26  J-type instr_index field.
REQ-010 Port: imem_addr  output  32  byte address to instruction memory select input.
REQ-011 Port: imem_data  input  32  instruction word from instruction memory; combinational, same cycle.
REQ-012 Port: if_instr  output  32  IF/ID instruction word.
REQ-013 Port: if_pc  output  32  IF/ID address of if_instr.
REQ-014 Port: if_pc_plus4  output  32  IF/ID if_pc+4.
REQ-015 Port: if_valid  output  1  IF/ID holds a real instruction.
REQ-016 Port: fetch_count  output  32  count of instructions loaded into IF/ID.

Function
REQ-017 imem_addr SHALL equal the PC register combinationally; zero-cycle fetch latency, one-cycle IF/ID latency.
REQ-018 Next-PC priority SHALL be: rst > branch_taken > jump > stall (hold) > PC+4.
REQ-019 Jump target SHALL be {if_pc_plus4[31:28], jump_index, 2'b00}.
REQ-020 Any redirect target SHALL have bits [1:0] forced to 2'b00 before loading PC.
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-022 If branch_taken and jump are both high, the branch SHALL win; jump is ignored.
REQ-023 IF/ID update priority SHALL be: rst > (flush | branch_taken | jump) -> bubble > stall -> hold > load.
REQ-024 Bubble SHALL set if_valid=0, if_instr=32'h0 (NOP), if_pc=0, if_pc_plus4=0.
REQ-025 Load SHALL capture if_instr=imem_data, if_pc=PC, if_pc_plus4=PC+4, if_valid=1.
REQ-026 Redirect with stall simultaneously: PC SHALL take the target and IF/ID SHALL bubble; stall is overridden.
REQ-027 flush without redirect SHALL still advance PC per REQ-018 (stall respected).
REQ-028 fetch_count SHALL increment by 1 on each load cycle only, wrapping 32'hFFFF_FFFF -> 0.

Reset
REQ-029 On rst: PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, fetch_count=0.
REQ-030 rst asserted mid-stall or mid-redirect SHALL override all other inputs that cycle.
REQ-031 In the first cycle after rst deasserts, imem_addr SHALL equal RESET_PC.

Structure
REQ-032 Opcode constants, NOP word (32'h0) and RESET_PC default SHALL reside in the shared MIPS definitions file used by instruction memory and decode.
REQ-033 Next-PC selection SHALL be a combinational sub-module named next_pc_sel; PC and IF/ID registers stay in fetch_unit.

Verification
REQ-034 Reset then 4 free-running cycles -> imem_addr 0,4,8,12; if_pc 0,4,8; if_valid=1 from cycle 2; fetch_count=3.
REQ-035 Stall 2 cycles at PC=8 -> imem_addr holds 8, IF/ID holds if_pc=4, fetch_count frozen.
REQ-036 branch_taken=1, branch_target=32'h10 at PC=32 -> next imem_addr=16, if_valid=0 one cycle, then if_pc=16.
REQ-037 jump=1, jump_index=0, if_pc_plus4=32'h34, branch_taken=1, branch_target=32'h21 -> PC=32'h20 (branch wins, bits masked).
REQ-038 PC preset via branch to 32'hFFFF_FFFC, no stall -> next imem_addr=0, if_pc_plus4=0.
REQ-039 rst=1 while stall=1 and jump=1 -> PC=RESET_PC, all IF/ID outputs and fetch_count 0 next cycle.
